// File: rtl/row_recursion_pkg.sv
// ============================================================================
//  Module      : row_recursion_pkg
//  Description : Shared types and width helpers for the row recursion sequencer.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package row_recursion_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

    // Width helpers kept >= 1 so degenerate parameters still elaborate.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int state_w(input int num_states);
        return (num_states > 1) ? $clog2(num_states) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/row_recursion_delay.sv
// ============================================================================
//  Module      : row_recursion_delay
//  Description : LATENCY-deep valid+address shift register, synchronous reset.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module row_recursion_delay #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr
);

    generate
        if (LATENCY == 0) begin : g_bypass
            assign o_valid = i_valid;
            assign o_addr  = i_addr;
        end else begin : g_pipe
            logic              r_valid_q [LATENCY];
            logic              r_valid_d [LATENCY];
            logic [ADDR_W-1:0] r_addr_q  [LATENCY];
            logic [ADDR_W-1:0] r_addr_d  [LATENCY];

            always_comb begin
                r_valid_d[0] = i_valid;
                r_addr_d[0]  = i_addr;
                for (int i = 1; i < LATENCY; i++) begin
                    r_valid_d[i] = r_valid_q[i-1];
                    r_addr_d[i]  = r_addr_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        r_valid_q[i] <= 1'b0;
                        r_addr_q[i]  <= '0;
                    end
                end else begin
                    r_valid_q <= r_valid_d;
                    r_addr_q  <= r_addr_d;
                end
            end

            assign o_valid = r_valid_q[LATENCY-1];
            assign o_addr  = r_addr_q[LATENCY-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/row_recursion_ctrl.sv
// ============================================================================
//  Module      : row_recursion_ctrl
//  Description : Step sequencer for the SISO row (alpha/beta) recursion.
//                Define ROW_RECURSION_WATCHDOG_EN to add the DRAIN watchdog.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module row_recursion_ctrl
    import row_recursion_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int DEPTH_RAM  = 3072,
    parameter int NUM_STATES = 8,
    parameter int RD_LATENCY = 1,
    parameter int MAX_STEPS  = DEPTH_RAM / NUM_STATES - 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          i_start,
    input  logic                          i_dir,
    input  logic [$clog2(DEPTH_RAM)-1:0]  i_block_len,
    output logic                          o_rd_en,
    output logic [$clog2(DEPTH_RAM)-1:0]  o_rd_step,
    output logic [$clog2(NUM_STATES)-1:0] o_rd_state,
    output logic                          o_calc_valid,
    output logic [$clog2(DEPTH_RAM)-1:0]  o_calc_addr,
    input  logic                          i_wb_valid,
    output logic                          o_busy,
    output logic                          o_done,
`ifdef ROW_RECURSION_WATCHDOG_EN
    output logic                          o_wd_err,
`endif
    output logic                          o_len_err
);

    localparam int c_addr_w  = addr_w(DEPTH_RAM);
    localparam int c_state_w = state_w(NUM_STATES);

    localparam logic [c_addr_w-1:0]  c_max_steps  = c_addr_w'(MAX_STEPS);
    localparam logic [c_addr_w-1:0]  c_addr_one   = c_addr_w'(1);
    localparam logic [c_state_w-1:0] c_state_one  = c_state_w'(1);
    localparam logic [c_state_w-1:0] c_last_state = c_state_w'(NUM_STATES - 1);
    localparam logic [c_state_w:0]   c_wb_full    = (c_state_w + 1)'(NUM_STATES);

    generate
        if ((NUM_STATES < 2) || ((NUM_STATES & (NUM_STATES - 1)) != 0) || (DWIDTH < 1)) begin : g_param_check
            $error("row_recursion_ctrl: NUM_STATES must be a power of two >= 2 and DWIDTH >= 1");
        end
    endgenerate

    fsm_state_e            r_fsm_q,        r_fsm_d;
    logic                  r_dir_q,        r_dir_d;
    logic [c_addr_w-1:0]   r_len_q,        r_len_d;
    logic [c_addr_w-1:0]   r_step_q,       r_step_d;
    logic [c_state_w-1:0]  r_state_q,      r_state_d;
    logic [c_state_w:0]    r_wb_cnt_q,     r_wb_cnt_d;
    logic [c_addr_w-1:0]   r_steps_done_q, r_steps_done_d;

    logic [c_addr_w-1:0]   w_len_clamped;
    logic [c_state_w:0]    w_wb_next;
    logic                  w_step_done;
    logic                  w_last_step;
    logic [c_addr_w-1:0]   w_row_base;
    logic [c_addr_w-1:0]   w_wr_addr;
    logic                  w_rd_en;
    logic                  w_len_err;

`ifdef ROW_RECURSION_WATCHDOG_EN
    localparam logic [15:0] c_wd_limit = 16'd63;
    logic [15:0]           r_wd_cnt_q,     r_wd_cnt_d;
    logic                  w_wd_err;
`endif

    assign w_len_clamped = (i_block_len > c_max_steps) ? c_max_steps : i_block_len;
    assign w_wb_next     = r_wb_cnt_q + {{c_state_w{1'b0}}, i_wb_valid};
    assign w_step_done   = (r_fsm_q == DRAIN) && (w_wb_next == c_wb_full);
    assign w_last_step   = ((r_steps_done_q + c_addr_one) == r_len_q);
    assign w_rd_en       = (r_fsm_q == ISSUE);

    // Destination row is the neighbouring step; NUM_STATES is a power of two,
    // so the row offset is a shift and the state fills the low bits.
    assign w_row_base = (r_dir_q == DIR_FWD) ? (r_step_q + c_addr_one) : (r_step_q - c_addr_one);
    assign w_wr_addr  = (w_row_base << c_state_w) | {{(c_addr_w - c_state_w){1'b0}}, r_state_q};

    always_comb begin
        r_fsm_d        = r_fsm_q;
        r_dir_d        = r_dir_q;
        r_len_d        = r_len_q;
        r_step_d       = r_step_q;
        r_state_d      = r_state_q;
        r_wb_cnt_d     = r_wb_cnt_q;
        r_steps_done_d = r_steps_done_q;
        w_len_err      = 1'b0;
`ifdef ROW_RECURSION_WATCHDOG_EN
        r_wd_cnt_d     = 16'd0;
        w_wd_err       = 1'b0;
`endif

        // Write-backs may overlap the tail of ISSUE when the pipe is short.
        if (((r_fsm_q == ISSUE) || (r_fsm_q == DRAIN)) && i_wb_valid) begin
            r_wb_cnt_d = w_wb_next;
        end

        case (r_fsm_q)
            IDLE: begin
                if (i_start) begin
                    r_dir_d        = i_dir;
                    r_len_d        = w_len_clamped;
                    w_len_err      = (i_block_len > c_max_steps);
                    r_step_d       = (i_dir == DIR_BWD) ? w_len_clamped : '0;
                    r_state_d      = '0;
                    r_wb_cnt_d     = '0;
                    r_steps_done_d = '0;
                    r_fsm_d        = (w_len_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                r_state_d = r_state_q + c_state_one;
                if (r_state_q == c_last_state) begin
                    r_fsm_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_step_done) begin
                    r_wb_cnt_d     = '0;
                    r_step_d       = (r_dir_q == DIR_FWD) ? (r_step_q + c_addr_one) : (r_step_q - c_addr_one);
                    r_steps_done_d = r_steps_done_q + c_addr_one;
                    r_fsm_d        = w_last_step ? DONE : ISSUE;
                end
`ifdef ROW_RECURSION_WATCHDOG_EN
                else if (r_wd_cnt_q == c_wd_limit) begin
                    w_wd_err = 1'b1;
                    r_fsm_d  = DONE;
                end else begin
                    r_wd_cnt_d = r_wd_cnt_q + 16'd1;
                end
`endif
            end
            DONE: begin
                r_fsm_d = IDLE;
            end
            default: begin
                r_fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_fsm_q        <= IDLE;
            r_dir_q        <= DIR_FWD;
            r_len_q        <= '0;
            r_step_q       <= '0;
            r_state_q      <= '0;
            r_wb_cnt_q     <= '0;
            r_steps_done_q <= '0;
        end else begin
            r_fsm_q        <= r_fsm_d;
            r_dir_q        <= r_dir_d;
            r_len_q        <= r_len_d;
            r_step_q       <= r_step_d;
            r_state_q      <= r_state_d;
            r_wb_cnt_q     <= r_wb_cnt_d;
            r_steps_done_q <= r_steps_done_d;
        end
    end

`ifdef ROW_RECURSION_WATCHDOG_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wd_cnt_q <= 16'd0;
        end else begin
            r_wd_cnt_q <= r_wd_cnt_d;
        end
    end

    assign o_wd_err = w_wd_err;
`endif

    row_recursion_delay #(
        .ADDR_W  (c_addr_w),
        .LATENCY (RD_LATENCY)
    ) u_delay (
        .clk     (aclk),
        .rst     (areset),
        .i_valid (w_rd_en),
        .i_addr  (w_wr_addr),
        .o_valid (o_calc_valid),
        .o_addr  (o_calc_addr)
    );

    assign o_rd_en    = w_rd_en;
    assign o_rd_step  = w_rd_en ? r_step_q  : '0;
    assign o_rd_state = w_rd_en ? r_state_q : '0;
    assign o_busy     = (r_fsm_q == ISSUE) || (r_fsm_q == DRAIN);
    assign o_done     = (r_fsm_q == DONE);
    assign o_len_err  = w_len_err;

endmodule

`default_nettype wire

// File: doc/row_recursion_ctrl.md
Name: row_recursion_ctrl

Overview:
- Sequencer for the row (state-metric) recursion datapath of the SISO decoder.
- Walks trellis steps k of one block, forward (alpha) or backward (beta).
- For each step it issues one request per destination state to the row-calc datapath.
- It waits for all write-backs of a step before starting the next step, because step k+1 reads the rows step k writes.

Parameters:
- DWIDTH, 16, metric width; passed through only, used for package consistency.
- DEPTH_RAM, 3072, row RAM depth; address width is $clog2(DEPTH_RAM).
- NUM_STATES, 8, trellis states per step; must be a power of two.
- RD_LATENCY, 1, row/branch RAM read latency in aclk cycles, from o_rd_en to data at the datapath.
- MAX_STEPS, DEPTH_RAM/NUM_STATES-1, largest legal block length.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_dir  in  1  0 = forward, 1 = backward; latched on accepted start
- i_block_len  in  $clog2(DEPTH_RAM)  number of steps K; latched on accepted start
- o_rd_en  out  1  row/branch RAM read strobe
- o_rd_step  out  $clog2(DEPTH_RAM)  step index being read
- o_rd_state  out  $clog2(NUM_STATES)  destination state; the trellis ROM maps it to predecessors
- o_calc_valid  out  1  to datapath i_valid; o_rd_en delayed RD_LATENCY cycles
- o_calc_addr  out  $clog2(DEPTH_RAM)  write-back row address, aligned with o_calc_valid
- i_wb_valid  in  1  datapath o_valid (write-back occurred)
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle pulse at block end
- o_len_err  out  1  one-cycle pulse when i_block_len > MAX_STEPS

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters and delay line cleared. Reset mid-block aborts silently; no o_done.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - i_start=1 latches i_dir and len = min(i_block_len, MAX_STEPS).
  - If i_block_len > MAX_STEPS, o_len_err pulses in the same cycle.
  - len=0 goes to DONE; otherwise goes to ISSUE, with step = 0 (forward) or len (backward) and state = 0.
- ISSUE: one request per cycle.
  - o_rd_en=1, o_rd_step=step, o_rd_state=state.
  - Write address wa = (step+1)*NUM_STATES+state forward, (step-1)*NUM_STATES+state backward.
  - wa enters the delay line and appears on o_calc_addr with o_calc_valid exactly RD_LATENCY cycles later.
  - state increments each cycle. After state NUM_STATES-1, go to DRAIN.
- DRAIN:
  - No issue. wb_cnt counts i_wb_valid pulses.
  - When wb_cnt reaches NUM_STATES (the counting pulse included): clear wb_cnt, advance step (+1 forward, -1 backward), and count one completed step.
  - If completed steps = len, go to DONE; else go to ISSUE next cycle.
- DONE: o_done=1 for one cycle, then IDLE. o_busy falls in the same cycle o_done is high.
- i_wb_valid outside DRAIN increments wb_cnt; it can legally arrive during ISSUE when latency < NUM_STATES. wb_cnt is cleared only at step completion.
- i_start while o_busy is ignored.
- Arithmetic: addresses are unsigned, width $clog2(DEPTH_RAM). Clamping guarantees no wrap.
- Timing: minimum steady-state step period is NUM_STATES + RD_LATENCY + datapath latency cycles.

Optional Feature:
- Macro: ROW_RECURSION_WATCHDOG_EN.
- With it: adds output o_wd_err (1 bit) and a 16-bit cycle counter in DRAIN.
  - If wb_cnt fails to reach NUM_STATES within 64 DRAIN cycles, o_wd_err pulses and the FSM goes to DONE.
  - o_done still pulses in that case.
- Without it: no port and no counter; DRAIN waits indefinitely.

Decomposition:
- Package row_recursion_pkg holds:
  - FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
  - ADDR_W and STATE_W localparam functions
  - direction constants DIR_FWD=0, DIR_BWD=1
- One sub-module, row_recursion_delay: RD_LATENCY-deep valid+address shift register with synchronous reset.

Test Plan:
- Forward, K=2, NUM_STATES=8, datapath model latency 5:
  - o_rd_step 0 for 8 cycles, then 1 for 8 cycles.
  - o_calc_addr 8..15 then 16..23.
  - o_done once, after the 16th i_wb_valid.
- Backward, K=3:
  - o_rd_step 3, 2, 1.
  - o_calc_addr 16..23, 8..15, 0..7.
  - No issue while wb_cnt < 8.
- i_block_len=0 -> o_done one cycle after start, no o_rd_en. i_block_len=400 (>383) -> o_len_err pulse, 383 steps run.
- Reset asserted in the 3rd ISSUE cycle of step 1 -> all outputs 0 next cycle; a new start runs a clean block.
- i_start pulsed during DRAIN -> ignored; only one o_done.
- With ROW_RECURSION_WATCHDOG_EN: model drops one i_wb_valid -> o_wd_err after 64 DRAIN cycles, o_done the next cycle.
